// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver.
// Contents:
//   seg7_t        - segment vector {a,b,c,d,e,f,g}, bit 6 = a, active-high view
//   SEG_0..SEG_F  - glyphs for codes 0-15, SEG_BLANK for all segments off
//   scan_state_t  - per-cycle scan phase: OFF, BLANK (anti-ghost gap), DRIVE
package seven_seg_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_0     = 7'b1111110;
   localparam seg7_t SEG_1     = 7'b0110000;
   localparam seg7_t SEG_2     = 7'b1101101;
   localparam seg7_t SEG_3     = 7'b1111001;
   localparam seg7_t SEG_4     = 7'b0110011;
   localparam seg7_t SEG_5     = 7'b1011011;
   localparam seg7_t SEG_6     = 7'b1011111;
   localparam seg7_t SEG_7     = 7'b1110000;
   localparam seg7_t SEG_8     = 7'b1111111;
   localparam seg7_t SEG_9     = 7'b1111011;
   localparam seg7_t SEG_A     = 7'b1110111;
   localparam seg7_t SEG_B     = 7'b0011111;
   localparam seg7_t SEG_C     = 7'b1001110;
   localparam seg7_t SEG_D     = 7'b0111101;
   localparam seg7_t SEG_E     = 7'b1001111;
   localparam seg7_t SEG_F     = 7'b1000111;
   localparam seg7_t SEG_BLANK = 7'b0000000;

   typedef enum logic [1:0] {
      OFF,
      BLANK,
      DRIVE
   } scan_state_t;

endpackage

// File: rtl/seven_seg_glyph_dec.sv
// Combinational 4-bit code to seven-segment glyph decoder (active-high view).
// Ports:
//   code     in  4  digit code to decode
//   hex_mode in  1  1: codes 10-15 show A,b,C,d,E,F; 0: they decode blank
//   seg      out 7  glyph {a,b,c,d,e,f,g}
//   invalid  out 1  code >9 while hex_mode=0
module seven_seg_glyph_dec
   import seven_seg_pkg::*;
(
   input  logic [3:0] code,
   input  logic       hex_mode,
   output seg7_t      seg,
   output logic       invalid
);

   always_comb begin
      seg     = SEG_BLANK;
      invalid = 1'b0;
      case (code)
         4'd0:  seg = SEG_0;
         4'd1:  seg = SEG_1;
         4'd2:  seg = SEG_2;
         4'd3:  seg = SEG_3;
         4'd4:  seg = SEG_4;
         4'd5:  seg = SEG_5;
         4'd6:  seg = SEG_6;
         4'd7:  seg = SEG_7;
         4'd8:  seg = SEG_8;
         4'd9:  seg = SEG_9;
         4'd10: seg = SEG_A;
         4'd11: seg = SEG_B;
         4'd12: seg = SEG_C;
         4'd13: seg = SEG_D;
         4'd14: seg = SEG_E;
         default: seg = SEG_F;
      endcase
      // Decimal-only displays must not show letters.
      if (!hex_mode && (code > 4'd9)) begin
         seg     = SEG_BLANK;
         invalid = 1'b1;
      end
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver. Holds a packed digit word,
// scans one digit per slot of REFRESH_DIV clocks (the first GHOST_BLANK clocks
// of each slot keep every digit dark to avoid ghosting), and drives shared
// segment lines plus a one-hot digit enable. New values are staged in a shadow
// register and only become visible at a frame boundary so a frame never tears.
// Ports:
//   clk        in  1           system clock, rising edge
//   rst_n      in  1           asynchronous active-low reset
//   en         in  1           0: display dark, scan held at slot 0
//   load       in  1           strobe: capture digits_in / dp_in
//   digits_in  in  4*N_DIGITS  digit i = [4i+3:4i], digit 0 least significant
//   dp_in      in  N_DIGITS    decimal point per digit
//   lz_blank   in  1           enable leading-zero blanking
//   seg_out    out 7           segments {a..g} at pin polarity
//   dp_out     out 1           decimal point at pin polarity
//   an_out     out N_DIGITS    one-hot digit enable at pin polarity
//   frame_tick out 1           pulse on the scan wrap from digit N-1 to 0
//   bcd_err    out 1           any active digit >9 (decimal mode only)
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int REFRESH_DIV    = 1000,
   parameter int GHOST_BLANK    = 2,
   parameter int HEX_MODE       = 0,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   digits_in,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic                    lz_blank,
   output seg7_t                   seg_out,
   output logic                    dp_out,
   output logic [N_DIGITS-1:0]     an_out,
   output logic                    frame_tick,
   output logic                    bcd_err
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_GB   = CNT_W'(GHOST_BLANK);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   // Pin levels that mean "off"; XOR with these converts the active-high view.
   localparam seg7_t               SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                DP_IDLE  = (SEG_ACTIVE_LOW != 0);
   localparam logic [N_DIGITS-1:0] AN_IDLE  = {N_DIGITS{AN_ACTIVE_LOW != 0}};

   logic [CNT_W-1:0]      cnt_reg;
   logic [IDX_W-1:0]      idx_reg;
   logic [4*N_DIGITS-1:0] shadow_reg;
   logic [N_DIGITS-1:0]   shadow_dp_reg;
   logic [4*N_DIGITS-1:0] active_reg;
   logic [N_DIGITS-1:0]   active_dp_reg;
   logic                  pending_reg;

   scan_state_t           state;
   logic                  slot_last;
   logic                  frame_wrap;

   logic [3:0]            digit [N_DIGITS];
   logic [N_DIGITS-1:0]   digit_bad;
   logic [N_DIGITS:1]     zero_from;   // digits N-1..i are all zero
   logic [N_DIGITS-1:0]   lz_mask;

   logic [3:0]            cur_code;
   seg7_t                 glyph;
   logic                  glyph_invalid;

   seg7_t                 seg_next;
   logic                  dp_next;
   logic [N_DIGITS-1:0]   an_next;
   logic                  bcd_next;

   // ---------------- scan state ----------------
   assign slot_last  = (cnt_reg == CNT_LAST);
   assign frame_wrap = en && slot_last && (idx_reg == IDX_LAST);

   always_comb begin
      state = DRIVE;
      if (!en) begin
         state = OFF;
      end else if (cnt_reg < CNT_GB) begin
         state = BLANK;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         idx_reg <= '0;
      end else if (!en) begin
         cnt_reg <= '0;
         idx_reg <= '0;
      end else if (slot_last) begin
         cnt_reg <= '0;
         idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
      end else begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   // ---------------- shadow / active digit registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_reg    <= '0;
         shadow_dp_reg <= '0;
         active_reg    <= '0;
         active_dp_reg <= '0;
         pending_reg   <= 1'b0;
      end else if (!en) begin
         // Nothing is being shown, so there is no frame to protect.
         if (load) begin
            active_reg    <= digits_in;
            active_dp_reg <= dp_in;
            shadow_reg    <= digits_in;
            shadow_dp_reg <= dp_in;
            pending_reg   <= 1'b0;
         end
      end else if (load && frame_wrap) begin
         // Boundary coincides with the load: take the fresh value directly.
         active_reg    <= digits_in;
         active_dp_reg <= dp_in;
         pending_reg   <= 1'b0;
      end else if (load) begin
         shadow_reg    <= digits_in;
         shadow_dp_reg <= dp_in;
         pending_reg   <= 1'b1;
      end else if (frame_wrap && pending_reg) begin
         active_reg    <= shadow_reg;
         active_dp_reg <= shadow_dp_reg;
         pending_reg   <= 1'b0;
      end
   end

   // ---------------- per-digit views, leading-zero mask, range check ----------------
   assign zero_from[N_DIGITS] = 1'b1;
   assign lz_mask[0]          = 1'b0;

   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         assign digit[gi]     = active_reg[4*gi +: 4];
         assign digit_bad[gi] = (digit[gi] > 4'd9);
         if (gi > 0) begin : g_lz
            assign zero_from[gi] = (digit[gi] == 4'd0) && zero_from[gi+1];
            assign lz_mask[gi]   = lz_blank && zero_from[gi];
         end
      end
   endgenerate

   assign cur_code = digit[idx_reg];
   assign bcd_next = (HEX_MODE != 0) ? 1'b0 : (|digit_bad);

   seven_seg_glyph_dec u_glyph_dec (
      .code     (cur_code),
      .hex_mode (HEX_MODE != 0),
      .seg      (glyph),
      .invalid  (glyph_invalid)
   );

   // ---------------- output selection ----------------
   always_comb begin
      seg_next = SEG_BLANK;
      dp_next  = 1'b0;
      an_next  = '0;
      if (state == DRIVE) begin
         an_next[idx_reg] = 1'b1;
         seg_next         = (lz_mask[idx_reg] || glyph_invalid) ? SEG_BLANK : glyph;
         dp_next          = active_dp_reg[idx_reg];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out    <= SEG_IDLE;
         dp_out     <= DP_IDLE;
         an_out     <= AN_IDLE;
         frame_tick <= 1'b0;
         bcd_err    <= 1'b0;
      end else begin
         seg_out    <= seg_next ^ SEG_IDLE;
         dp_out     <= dp_next ^ DP_IDLE;
         an_out     <= an_next ^ AN_IDLE;
         frame_tick <= frame_wrap;
         bcd_err    <= bcd_next;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: a reference model pushes the expected pin values for
// every clock edge into a queue; a negedge monitor pops and compares them.
// A decimal-mode and a hex-mode instance share the same stimulus.
module tb_seven_seg_scan_driver;

   localparam int N  = 4;
   localparam int RD = 4;
   localparam int GB = 1;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        en        = 1'b0;
   logic        load      = 1'b0;
   logic        lz_blank  = 1'b0;
   logic [15:0] digits_in = 16'h0000;
   logic [3:0]  dp_in     = 4'h0;

   logic [6:0]  seg_out, seg_hex;
   logic        dp_out, dp_hex;
   logic [3:0]  an_out, an_hex;
   logic        frame_tick, ft_hex;
   logic        bcd_err, err_hex;

   always #5 clk = ~clk;

   seven_seg_scan_driver #(
      .N_DIGITS(N), .REFRESH_DIV(RD), .GHOST_BLANK(GB),
      .HEX_MODE(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
      .dp_in(dp_in), .lz_blank(lz_blank), .seg_out(seg_out), .dp_out(dp_out),
      .an_out(an_out), .frame_tick(frame_tick), .bcd_err(bcd_err)
   );

   seven_seg_scan_driver #(
      .N_DIGITS(N), .REFRESH_DIV(RD), .GHOST_BLANK(GB),
      .HEX_MODE(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
   ) dut_hex (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
      .dp_in(dp_in), .lz_blank(lz_blank), .seg_out(seg_hex), .dp_out(dp_hex),
      .an_out(an_hex), .frame_tick(ft_hex), .bcd_err(err_hex)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, got, want);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] d, input bit hex);
      case (d)
         4'h0: glyph = 7'b1111110;
         4'h1: glyph = 7'b0110000;
         4'h2: glyph = 7'b1101101;
         4'h3: glyph = 7'b1111001;
         4'h4: glyph = 7'b0110011;
         4'h5: glyph = 7'b1011011;
         4'h6: glyph = 7'b1011111;
         4'h7: glyph = 7'b1110000;
         4'h8: glyph = 7'b1111111;
         4'h9: glyph = 7'b1111011;
         4'hA: glyph = hex ? 7'b1110111 : 7'b0000000;
         4'hB: glyph = hex ? 7'b0011111 : 7'b0000000;
         4'hC: glyph = hex ? 7'b1001110 : 7'b0000000;
         4'hD: glyph = hex ? 7'b0111101 : 7'b0000000;
         4'hE: glyph = hex ? 7'b1001111 : 7'b0000000;
         default: glyph = hex ? 7'b1000111 : 7'b0000000;
      endcase
   endfunction

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic [6:0] seg_hex;
      logic       dp;
      logic       ft;
      logic       err;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   // ---------------- reference model ----------------
   int          m_cnt  = 0;
   int          m_idx  = 0;
   logic [15:0] m_act  = 16'h0;
   logic [3:0]  m_act_dp = 4'h0;
   logic [15:0] m_sh   = 16'h0;
   logic [3:0]  m_sh_dp = 4'h0;
   logic        m_pend = 1'b0;

   function automatic bit at_boundary();
      return en && (m_cnt == RD - 1) && (m_idx == N - 1);
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      logic [3:0] d;
      bit blank;
      e.an      = 4'hF;
      e.seg     = 7'h00;
      e.seg_hex = 7'h00;
      e.dp      = 1'b0;
      e.ft      = at_boundary();
      e.err     = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (m_act[4*i +: 4] > 4'd9) e.err = 1'b1;
      end
      if (en && (m_cnt >= GB)) begin
         d         = m_act[4*m_idx +: 4];
         blank     = lz_blank && (m_idx > 0) && ((m_act >> (4*m_idx)) == 16'h0);
         e.an      = ~(4'b0001 << m_idx);
         e.seg     = blank ? 7'h00 : glyph(d, 1'b0);
         e.seg_hex = blank ? 7'h00 : glyph(d, 1'b1);
         e.dp      = m_act_dp[m_idx];
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 0; m_idx <= 0; m_act <= 16'h0; m_act_dp <= 4'h0;
         m_sh <= 16'h0; m_sh_dp <= 4'h0; m_pend <= 1'b0;
      end else begin
         q.push_back(model_out());
         if (en) begin
            if (m_cnt == RD - 1) begin
               m_cnt <= 0;
               m_idx <= (m_idx == N - 1) ? 0 : m_idx + 1;
            end else begin
               m_cnt <= m_cnt + 1;
            end
            if (load && at_boundary()) begin
               m_act <= digits_in; m_act_dp <= dp_in; m_pend <= 1'b0;
            end else if (load) begin
               m_sh <= digits_in; m_sh_dp <= dp_in; m_pend <= 1'b1;
            end else if (at_boundary() && m_pend) begin
               m_act <= m_sh; m_act_dp <= m_sh_dp; m_pend <= 1'b0;
            end
         end else begin
            m_cnt <= 0;
            m_idx <= 0;
            if (load) begin
               m_act <= digits_in; m_act_dp <= dp_in;
            end
         end
      end
   end

   // While reset is held the pins must sit at their idle levels.
   always @(posedge clk) begin
      if (!rst_n) q.push_back('{an: 4'hF, seg: 7'h00, seg_hex: 7'h00, dp: 1'b0, ft: 1'b0, err: 1'b0});
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         check("an",      32'(an_out),     32'(mon_e.an));
         check("seg",     32'(seg_out),    32'(mon_e.seg));
         check("dp",      32'(dp_out),     32'(mon_e.dp));
         check("ftick",   32'(frame_tick), 32'(mon_e.ft));
         check("bcd_err", 32'(bcd_err),    32'(mon_e.err));
         check("an_hex",  32'(an_hex),     32'(mon_e.an));
         check("seg_hex", 32'(seg_hex),    32'(mon_e.seg_hex));
         check("err_hex", 32'(err_hex),    32'd0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      digits_in = d;
      dp_in     = p;
      load      = 1'b1;
      $display("load digits=%h dp=%b en=%0b lz=%0b t=%0t", d, p, en, lz_blank, $time);
      @(negedge clk);
      load = 1'b0;
   endtask

   // Waits until the next edge will sample the given slot position (idx<0: any digit).
   task automatic wait_slot(input int c, input int i, input string tag);
      bit found = 1'b0;
      for (int k = 0; k < 64 && !found; k++) begin
         if (m_cnt == c && (i < 0 || m_idx == i)) found = 1'b1;
         else @(negedge clk);
      end
      check(tag, 32'(found), 32'd1);
   endtask

   int ticks;

   initial begin
      cyc(3);
      rst_n = 1'b1;
      cyc(1);

      // Immediate load while dark, then scan 0x1234.
      do_load(16'h1234, 4'b0000);
      en = 1'b1;
      cyc(4);
      ticks = 0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (frame_tick) ticks++;
      end
      check("ftick_rate", 32'(ticks), 32'd2);

      // Leading-zero blanking on and off.
      lz_blank = 1'b1;
      do_load(16'h0007, 4'b0001);
      cyc(40);
      lz_blank = 1'b0;
      cyc(20);

      // Non-decimal code: blank + bcd_err in decimal, 'A' in hex.
      do_load(16'h00A5, 4'b0000);
      cyc(36);

      // Tear-free update: 0x2222 loaded mid-frame.
      do_load(16'h1111, 4'b1010);
      cyc(20);
      wait_slot(1, 1, "wait_mid");
      do_load(16'h2222, 4'b0000);
      cyc(36);

      // Two loads before the boundary: last one wins.
      wait_slot(0, 1, "wait_two");
      do_load(16'h3333, 4'b0000);
      do_load(16'h4444, 4'b1000);
      cyc(36);

      // Load coincident with the boundary cycle.
      wait_slot(RD - 1, N - 1, "wait_bnd");
      do_load(16'h5678, 4'b0100);
      cyc(20);

      // en dropped mid-slot, load while dark, re-enable.
      wait_slot(2, -1, "wait_drv");
      en = 1'b0;
      cyc(2);
      do_load(16'h9999, 4'b0000);
      cyc(2);
      en = 1'b1;
      cyc(24);

      // Asynchronous reset in the middle of a driven slot.
      wait_slot(2, -1, "wait_rst");
      #2 rst_n = 1'b0;
      #1;
      check("rst_an",     32'(an_out),  32'hF);
      check("rst_seg",    32'(seg_out), 32'h00);
      check("rst_dp",     32'(dp_out),  32'h0);
      check("rst_an_hex", 32'(an_hex),  32'hF);
      cyc(2);
      rst_n = 1'b1;
      cyc(24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
